// File: rtl/key_ctrl_pkg.sv
// Shared constants and elaboration helpers for the key conditioning stage.
package key_ctrl_pkg;

    // Channel indices as wired into the 0-99 s timer controls
    localparam int KEY_IDX_EN    = 0;
    localparam int KEY_IDX_STOP  = 1;
    localparam int KEY_IDX_CLEAR = 2;

    // Number of clock cycles a new level must hold before it is accepted
    function automatic int db_cycles(input int clk_hz, input int debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

    // Counter width able to hold 0..db inclusive
    function automatic int cnt_width(input int db);
        return (db < 1) ? 1 : $clog2(db + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce counter, clean level, edge pulses, toggle.
module key_debounce_ch
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES      = 4,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic toggle_clr,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic          IDLE_RAW = (KEY_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          sample;
    logic          differ;
    logic          accept;

    // Polarity normalisation: XOR with the idle raw level gives 1 = pressed
    assign sample = sync_q[1] ^ IDLE_RAW;
    assign differ = (sample != key_level);
    assign accept = differ && (cnt == CNT_LAST);

    // Two-flop synchroniser, reset to the idle raw level so reset looks "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{IDLE_RAW}};
        else        sync_q <= {sync_q[0], key_raw};
    end

    // Count consecutive differing samples; any agreement or an acceptance restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (!differ || accept) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

    // Stable level plus single-cycle edge pulses, all updated on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            if (accept) key_level <= sample;
            key_press   <= accept &  sample;
            key_release <= accept & ~sample;
        end
    end

    // Toggle flips the cycle after a press; clear wins over a coincident flip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         key_toggle <= 1'b0;
        else if (toggle_clr) key_toggle <= 1'b0;
        else if (key_press)  key_toggle <= ~key_toggle;
    end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Key/switch conditioning front end: N_KEYS independent debounced channels.
module key_debounce_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int N_KEYS         = 3,
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              toggle_clr,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle
);

    // Must come out >= 1 for the chosen clock and debounce time
    localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);

    // One channel per key; toggle_clr is common to all of them
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES      (DB_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw     (key_raw[i]),
            .toggle_clr  (toggle_clr),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_toggle  (key_toggle[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Self-checking bench: directed scenarios plus random bouncing against a window model.
module tb_key_debounce_ctrl;

    localparam int N  = 3;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_raw = '1;
    logic         toggle_clr = 1'b0;
    logic [N-1:0] key_level, key_press, key_release, key_toggle;

    int errors = 0;
    int checks = 0;

    key_debounce_ctrl #(
        .N_KEYS(N), .CLK_HZ(4000), .DEBOUNCE_MS(1), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .toggle_clr(toggle_clr),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_toggle(key_toggle)
    );

    always #5 clk = ~clk;

    // Reference model: a key's level flips once the last DB consumed samples
    // all disagree with it. Samples reach the debouncer two edges after capture.
    bit [N-1:0]  m_p1, m_p2, m_lvl, m_prs, m_rel, m_tog;
    bit [DB-1:0] m_win [N];

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_tog = '0;
        for (int i = 0; i < N; i++) m_win[i] = '0;
    endtask

    // Advance one clock edge, update the model with inputs seen at that edge,
    // then step 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            for (int i = 0; i < N; i++) begin
                if (toggle_clr)    m_tog[i] = 1'b0;
                else if (m_prs[i]) m_tog[i] = ~m_tog[i];
                m_win[i] = {m_win[i][DB-2:0], m_p2[i]};
                if (m_win[i] == {DB{~m_lvl[i]}}) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_prs[i] = m_lvl[i];
                    m_rel[i] = ~m_lvl[i];
                end else begin
                    m_prs[i] = 1'b0;
                    m_rel[i] = 1'b0;
                end
            end
            m_p2 = m_p1;
            m_p1 = ~key_raw;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [4*N-1:0] obs;
        rst_n = 1'b0; key_raw = '1; model_reset();
        for (int n = 0; n < 3; n++) tick();
        obs = {key_level, key_press, key_release, key_toggle};
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_hold obs=%h exp=0", obs); end
        rst_n = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            obs = {key_level, key_press, key_release, key_toggle};
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset_idle cyc=%0d obs=%h exp=0", n, obs); end
        end
    endtask

    task automatic test_single_press();
        logic [4*N-1:0] obs, exp;
        key_raw[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            obs = {key_level, key_press, key_release, key_toggle};
            exp = {m_lvl, m_prs, m_rel, m_tog};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL press_model cyc=%0d obs=%h exp=%h", n, obs, exp); end
            checks++;
            if (key_press !== {2'b00, n == 6}) begin
                errors++; $display("FAIL press_pulse cyc=%0d obs=%b exp=%b", n, key_press, {2'b00, n == 6});
            end
            checks++;
            if (key_level !== {2'b00, n >= 6} || key_toggle !== {2'b00, n >= 7}) begin
                errors++; $display("FAIL press_lvl_tog cyc=%0d lvl=%b tog=%b", n, key_level, key_toggle);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4*N-1:0] obs, exp;
        bit pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int p = 0; p < 4; p++) begin
            key_raw[1] = pat[p];
            for (int h = 0; h < 2; h++) begin
                tick();
                checks++;
                if (key_press[1] !== 1'b0 || key_level[1] !== 1'b0) begin
                    errors++; $display("FAIL bounce_quiet p=%0d prs=%b lvl=%b exp=0", p, key_press[1], key_level[1]);
                end
            end
        end
        key_raw[1] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            obs = {key_level, key_press, key_release, key_toggle};
            exp = {m_lvl, m_prs, m_rel, m_tog};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL bounce_model cyc=%0d obs=%h exp=%h", n, obs, exp); end
            checks++;
            if (key_press[1] !== (n == 6)) begin
                errors++; $display("FAIL bounce_pulse cyc=%0d obs=%b exp=%b", n, key_press[1], n == 6);
            end
        end
    endtask

    task automatic test_release_toggle();
        int prs_cnt = 0, rel_cnt = 0;
        logic [4*N-1:0] obs, exp;
        for (int c = 0; c < 2; c++) begin
            for (int ph = 0; ph < 2; ph++) begin
                key_raw[2] = ph[0];   // 0 = press, 1 = release
                for (int n = 0; n < 10; n++) begin
                    tick();
                    prs_cnt += key_press[2];
                    rel_cnt += key_release[2];
                    obs = {key_level, key_press, key_release, key_toggle};
                    exp = {m_lvl, m_prs, m_rel, m_tog};
                    checks++;
                    if (obs !== exp) begin errors++; $display("FAIL rel_model c=%0d obs=%h exp=%h", c, obs, exp); end
                end
            end
            checks++;
            if (key_toggle[2] !== (c == 0)) begin
                errors++; $display("FAIL rel_toggle c=%0d obs=%b exp=%b", c, key_toggle[2], c == 0);
            end
        end
        checks++;
        if (prs_cnt != 2 || rel_cnt != 2) begin
            errors++; $display("FAIL rel_counts press=%0d release=%0d exp=2/2", prs_cnt, rel_cnt);
        end
    endtask

    task automatic test_toggle_clr();
        bit seen = 0;
        key_raw[0] = 1'b1;
        for (int n = 0; n < 12; n++) tick();
        key_raw[0] = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = key_press[0];
        end
        checks++;
        if (!seen || key_toggle[0] !== 1'b1) begin
            errors++; $display("FAIL clr_setup seen=%0d tog=%b exp=1/1", seen, key_toggle[0]);
        end
        toggle_clr = 1'b1;
        tick();
        toggle_clr = 1'b0;
        checks++;
        if (key_toggle !== m_tog || key_toggle[0] !== 1'b0) begin
            errors++; $display("FAIL clr_wins obs=%b exp=%b", key_toggle, m_tog);
        end
    endtask

    task automatic test_reset_mid();
        logic [4*N-1:0] obs;
        key_raw = '1;
        for (int n = 0; n < 12; n++) tick();
        key_raw[0] = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        rst_n = 1'b0; model_reset();
        #1;
        for (int n = 0; n < 4; n++) begin
            obs = {key_level, key_press, key_release, key_toggle};
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL rstmid_hold cyc=%0d obs=%h exp=0", n, obs); end
            tick();
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (key_press !== {2'b00, n == 6} || key_level[0] !== (n >= 6)) begin
                errors++; $display("FAIL rstmid_press cyc=%0d prs=%b lvl=%b", n, key_press, key_level);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit seen = 0;
        key_raw = '1;
        for (int n = 0; n < 12; n++) tick();
        key_raw = '0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = (key_press != '0);
        end
        checks++;
        if (key_press !== 3'b111) begin errors++; $display("FAIL simul_press obs=%b exp=111", key_press); end
        for (int n = 0; n < 30; n++) begin
            tick();
            checks++;
            if (key_press !== '0 || key_level !== 3'b111) begin
                errors++; $display("FAIL held_quiet cyc=%0d prs=%b lvl=%b", n, key_press, key_level);
            end
        end
    endtask

    task automatic test_random();
        logic [4*N-1:0] obs, exp;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) key_raw[i] = ~key_raw[i];
            toggle_clr = ($urandom_range(0, 19) == 0);
            tick();
            obs = {key_level, key_press, key_release, key_toggle};
            exp = {m_lvl, m_prs, m_rel, m_tog};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", n, obs, exp); end
        end
        toggle_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_release_toggle();
        test_toggle_clr();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
